ex_m_buffer: RTL and testbench



---
 rtl/ex_m_buffer_if.sv | 42 ++++
 rtl/ex_m_buffer.sv | 64 ++++++
 tb/tb_ex_m_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ex_m_buffer_if.sv
// EX->M pipeline bundle: Execute-side inputs and Memory-side registered outputs.
// The master modport is the side that drives the EX fields and reads the M fields.
interface ex_m_buffer_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  logic              mWrite;
  logic              mRead;
  logic              mByte;
  logic [1:0]        rWrite;
  logic [REG_W-1:0]  op1;
  logic [REG_W-1:0]  op2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] op1data;
  logic [DATA_W-1:0] op2data;
  logic [DATA_W-1:0] r15data;

  logic              mWriteOut;
  logic              mReadOut;
  logic              mByteOut;
  logic [1:0]        rWriteOut;
  logic [REG_W-1:0]  op1Out;
  logic [REG_W-1:0]  op2Out;
  logic [DATA_W-1:0] data1Out;
  logic [DATA_W-1:0] op1dataOut;
  logic [DATA_W-1:0] op2dataOut;
  logic [DATA_W-1:0] r15dataOut;

  modport master (
    output mWrite, mRead, mByte, rWrite, op1, op2,
           data1, op1data, op2data, r15data,
    input  mWriteOut, mReadOut, mByteOut, rWriteOut, op1Out, op2Out,
           data1Out, op1dataOut, op2dataOut, r15dataOut
  );

  modport slave (
    input  mWrite, mRead, mByte, rWrite, op1, op2,
           data1, op1data, op2data, r15data,
    output mWriteOut, mReadOut, mByteOut, rWriteOut, op1Out, op2Out,
           data1Out, op1dataOut, op2dataOut, r15dataOut
  );
endinterface

// File: rtl/ex_m_buffer.sv
// EX->M pipeline register: a one-cycle, resettable delay of the control/data bundle.
// Reset clears everything, which the Memory stage sees as a bubble.
module ex_m_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_m_buffer_if.slave bus
);
  localparam int N_DATA = 4;

  logic              mwrite_reg;
  logic              mread_reg;
  logic              mbyte_reg;
  logic [1:0]        rwrite_reg;
  logic [REG_W-1:0]  op1_reg;
  logic [REG_W-1:0]  op2_reg;
  logic [DATA_W-1:0] data_in  [N_DATA];
  logic [DATA_W-1:0] data_reg [N_DATA];

  // Data words handled as one array: 0=data1, 1=op1data, 2=op2data, 3=r15data.
  assign data_in[0] = bus.data1;
  assign data_in[1] = bus.op1data;
  assign data_in[2] = bus.op2data;
  assign data_in[3] = bus.r15data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mwrite_reg <= 1'b0;
      mread_reg  <= 1'b0;
      mbyte_reg  <= 1'b0;
      rwrite_reg <= 2'b00;
      op1_reg    <= '0;
      op2_reg    <= '0;
    end else begin
      mwrite_reg <= bus.mWrite;
      mread_reg  <= bus.mRead;
      mbyte_reg  <= bus.mByte;
      rwrite_reg <= bus.rWrite;
      op1_reg    <= bus.op1;
      op2_reg    <= bus.op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DATA; i++) data_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_DATA; i++) data_reg[i] <= data_in[i];
    end
  end

  assign bus.mWriteOut  = mwrite_reg;
  assign bus.mReadOut   = mread_reg;
  assign bus.mByteOut   = mbyte_reg;
  assign bus.rWriteOut  = rwrite_reg;
  assign bus.op1Out     = op1_reg;
  assign bus.op2Out     = op2_reg;
  assign bus.data1Out   = data_reg[0];
  assign bus.op1dataOut = data_reg[1];
  assign bus.op2dataOut = data_reg[2];
  assign bus.r15dataOut = data_reg[3];
endmodule

// File: tb/tb_ex_m_buffer.sv
// Directed bench for ex_m_buffer: reset, capture/hold, a vector table of
// back-to-back bundles, and an asynchronous mid-cycle reset.
module tb_ex_m_buffer;
  typedef struct packed {
    logic        mwrite;
    logic        mread;
    logic        mbyte;
    logic [1:0]  rwrite;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [15:0] data1;
    logic [15:0] op1data;
    logic [15:0] op2data;
    logic [15:0] r15data;
  } bundle_t;

  typedef struct {
    string   name;
    bundle_t in;
    bundle_t exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ex_m_buffer_if #(.DATA_W(16), .REG_W(4)) bus ();

  ex_m_buffer #(.DATA_W(16), .REG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bundle_t b);
    bus.mWrite  = b.mwrite;
    bus.mRead   = b.mread;
    bus.mByte   = b.mbyte;
    bus.rWrite  = b.rwrite;
    bus.op1     = b.op1;
    bus.op2     = b.op2;
    bus.data1   = b.data1;
    bus.op1data = b.op1data;
    bus.op2data = b.op2data;
    bus.r15data = b.r15data;
  endtask

  function automatic bundle_t outputs();
    bundle_t b;
    b.mwrite  = bus.mWriteOut;
    b.mread   = bus.mReadOut;
    b.mbyte   = bus.mByteOut;
    b.rwrite  = bus.rWriteOut;
    b.op1     = bus.op1Out;
    b.op2     = bus.op2Out;
    b.data1   = bus.data1Out;
    b.op1data = bus.op1dataOut;
    b.op2data = bus.op2dataOut;
    b.r15data = bus.r15dataOut;
    return b;
  endfunction

  task automatic check(input string name, input bundle_t exp);
    bundle_t got;
    got = outputs();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, got, $time);
    end
  endtask

  localparam bundle_t ZERO = '0;
  // {mW,mR,mB,rW,op1,op2,data1,op1data,op2data,r15data}
  localparam bundle_t RST_IN  = '{1'b1, 1'b0, 1'b0, 2'b01, 4'h0, 4'h0, 16'h00A0, 16'h0000, 16'h0000, 16'h0000};
  localparam bundle_t CAP     = '{1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h1, 16'h00A0, 16'h00FF, 16'h0082, 16'h0015};
  localparam bundle_t HOLD    = '{1'b1, 1'b1, 1'b1, 2'b01, 4'h1, 4'h4, 16'h0000, 16'h00CC, 16'h0031, 16'h0090};
  localparam bundle_t POSTRST = '{1'b0, 1'b1, 1'b0, 2'b10, 4'h3, 4'h7, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  vec_t vecs [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{"b2b_0",  '{1'b0,1'b1,1'b0,2'b10,4'h2,4'h3,16'h0101,16'h0202,16'h0303,16'h0404},
                          '{1'b0,1'b1,1'b0,2'b10,4'h2,4'h3,16'h0101,16'h0202,16'h0303,16'h0404}};
    vecs[1] = '{"b2b_1",  '{1'b1,1'b0,1'b1,2'b11,4'h5,4'h6,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF},
                          '{1'b1,1'b0,1'b1,2'b11,4'h5,4'h6,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF}};
    vecs[2] = '{"b2b_2",  '{1'b0,1'b0,1'b1,2'b01,4'h7,4'h8,16'h8001,16'h4002,16'h2004,16'h1008},
                          '{1'b0,1'b0,1'b1,2'b01,4'h7,4'h8,16'h8001,16'h4002,16'h2004,16'h1008}};
    vecs[3] = '{"b2b_3",  '{1'b1,1'b1,1'b0,2'b00,4'h9,4'hA,16'h0010,16'h0020,16'h0040,16'h0080},
                          '{1'b1,1'b1,1'b0,2'b00,4'h9,4'hA,16'h0010,16'h0020,16'h0040,16'h0080}};
    vecs[4] = '{"width_a",'{1'b1,1'b1,1'b1,2'b11,4'hF,4'hE,16'hA5A5,16'h5A5A,16'hA5A5,16'h5A5A},
                          '{1'b1,1'b1,1'b1,2'b11,4'hF,4'hE,16'hA5A5,16'h5A5A,16'hA5A5,16'h5A5A}};
    vecs[5] = '{"width_b",'{1'b0,1'b0,1'b0,2'b10,4'hE,4'hF,16'h5A5A,16'hA5A5,16'h5A5A,16'hA5A5},
                          '{1'b0,1'b0,1'b0,2'b10,4'hE,4'hF,16'h5A5A,16'hA5A5,16'h5A5A,16'hA5A5}};

    // Reset asserted between edges with nonzero inputs must clear at once.
    rst_n = 1'b1;
    drive(RST_IN);
    #2 rst_n = 1'b0;
    #1 check("reset_async", ZERO);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold_%0d", i), ZERO);
    end

    // Release reset and capture the first bundle.
    @(negedge clk);
    rst_n = 1'b1;
    drive(CAP);
    check("release_no_edge", ZERO);
    @(posedge clk);
    #2 drive(HOLD);
    #1 check("capture", CAP);
    @(negedge clk);
    check("hold_between_edges", CAP);
    @(posedge clk);
    #1 check("hold_next_edge", HOLD);

    // Table: each bundle must appear exactly one edge after it is driven.
    for (int i = 0; i < 6; i++) begin
      bundle_t prev;
      prev = (i == 0) ? HOLD : vecs[i-1].exp;
      @(negedge clk);
      drive(vecs[i].in);
      #1 check({vecs[i].name, "_pre"}, prev);
      @(posedge clk);
      #1 check(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset mid-cycle with nonzero outputs, then reload.
    @(negedge clk);
    drive(POSTRST);
    rst_n = 1'b0;
    #1 check("midcycle_reset", ZERO);
    #1 rst_n = 1'b1;
    #1 check("reset_released_no_edge", ZERO);
    @(posedge clk);
    #1 check("reload_after_reset", POSTRST);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: bench did not finish, required finish before 5000");
    $fatal(1, "timeout");
  end
endmodule
